// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag controller for an asynchronous FIFO.
// Owns the binary read pointer, publishes it as Gray, and derives EMPTY, level and underflow.
module fifo_read_ctrl #(
    parameter int Addr_width = 5
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  R_INC,
    input  logic [Addr_width-1:0] Wr_gray_sync,
    output logic [Addr_width-2:0] R_addr,
    output logic [Addr_width-1:0] Rd_gray_ptr,
    output logic                  R_EMPTY,
    output logic [Addr_width-1:0] R_level,
    output logic                  R_underflow
);

    logic [Addr_width-1:0] rbin_q, rbin_d;
    logic [Addr_width-1:0] rgray_q, rgray_d;
    logic                  empty_q, empty_d;
    logic [Addr_width-1:0] level_q, level_d;
    logic                  underflow_q, underflow_d;
    logic [Addr_width-1:0] wbin;
    logic                  rd_en;

    // Gray-to-binary decode as a ripple of XOR2 stages, MSB first.
    for (genvar i = Addr_width - 1; i >= 0; i--) begin : g_dec
        logic b;
        if (i == Addr_width - 1) begin : g_msb
            assign b = Wr_gray_sync[i];
        end else begin : g_lsb
            assign b = g_dec[i+1].b ^ Wr_gray_sync[i];
        end
        assign wbin[i] = b;
    end

    always_comb begin
        rd_en       = R_INC & ~empty_q;
        rbin_d      = rbin_q + {{(Addr_width-1){1'b0}}, rd_en};
        rgray_d     = rbin_d ^ (rbin_d >> 1);
        empty_d     = (rgray_d == Wr_gray_sync);
        level_d     = wbin - rbin_d;
        underflow_d = R_INC & empty_q;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Gray pointer is driven straight from a flop so the write-side synchronizer never sees glitches.
    assign R_addr      = rbin_q[Addr_width-2:0];
    assign Rd_gray_ptr = rgray_q;
    assign R_EMPTY     = empty_q;
    assign R_level     = level_q;
    assign R_underflow = underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: occupancy-count reference model, per-cycle
// compare on the falling edge, directed scenarios plus randomized read/write traffic.
module tb_fifo_read_ctrl;

    localparam int AW    = 5;
    localparam int MOD   = 32;
    localparam int DEPTH = 16;

    logic          R_CLK = 1'b0;
    logic          R_RST;
    logic          R_INC;
    logic [AW-1:0] Wr_gray_sync;
    logic [AW-2:0] R_addr;
    logic [AW-1:0] Rd_gray_ptr;
    logic          R_EMPTY;
    logic [AW-1:0] R_level;
    logic          R_underflow;

    fifo_read_ctrl #(.Addr_width(AW)) dut (
        .R_CLK       (R_CLK),
        .R_RST       (R_RST),
        .R_INC       (R_INC),
        .Wr_gray_sync(Wr_gray_sync),
        .R_addr      (R_addr),
        .Rd_gray_ptr (Rd_gray_ptr),
        .R_EMPTY     (R_EMPTY),
        .R_level     (R_level),
        .R_underflow (R_underflow)
    );

    always #5 R_CLK = ~R_CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // Decode by search: the binary count whose Gray image matches.
    function automatic int from_gray(input logic [AW-1:0] g);
        for (int i = 0; i < MOD; i++)
            if (to_gray(i) == int'(g)) return i;
        return -1;
    endfunction

    // Reference model: read count, and what the registered flags must show.
    int   m_rd;
    int   m_level;
    int   m_gray;
    logic m_empty;
    logic m_uf;
    int   wcnt;

    always @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            m_rd    <= 0;
            m_level <= 0;
            m_gray  <= 0;
            m_empty <= 1'b1;
            m_uf    <= 1'b0;
        end else begin
            automatic int nrd = (m_rd + ((R_INC && !m_empty) ? 1 : 0)) % MOD;
            automatic int w   = from_gray(Wr_gray_sync);
            m_rd    <= nrd;
            m_level <= (w - nrd + MOD) % MOD;
            m_empty <= (w == nrd);
            m_uf    <= R_INC && m_empty;
            m_gray  <= to_gray(nrd);
        end
    end

    logic [AW-1:0] prev_gray;
    bit            chk_bound = 1'b1;

    always @(negedge R_CLK) begin
        if (R_RST) begin
            prev_gray <= '0;
        end else begin
            check("addr",      R_addr,      m_rd % DEPTH);
            check("gray",      Rd_gray_ptr, m_gray);
            check("empty",     R_EMPTY,     m_empty);
            check("level",     R_level,     m_level);
            check("underflow", R_underflow, m_uf);
            check("gray_step", ($countones(Rd_gray_ptr ^ prev_gray) <= 1), 1);
            if (chk_bound) check("level_bound", (R_level <= DEPTH), 1);
            prev_gray <= Rd_gray_ptr;
        end
    end

    // Drive one cycle from just after a falling edge; the writer never overfills.
    task automatic cycle(input logic inc, input logic wr);
        R_INC = inc;
        if (wr && ((wcnt - m_rd + MOD) % MOD) < DEPTH) begin
            wcnt         = (wcnt + 1) % MOD;
            Wr_gray_sync = AW'(to_gray(wcnt));
        end
        @(negedge R_CLK);
    endtask

    task automatic do_reset();
        R_RST        = 1'b1;
        R_INC        = 1'b0;
        wcnt         = 0;
        Wr_gray_sync = '0;
        @(negedge R_CLK);
        R_RST = 1'b0;
    endtask

    initial begin
        R_RST        = 1'b1;
        R_INC        = 1'b0;
        wcnt         = 0;
        Wr_gray_sync = '0;
        repeat (2) @(negedge R_CLK);
        check("rst_empty", R_EMPTY,     1);
        check("rst_level", R_level,     0);
        check("rst_gray",  Rd_gray_ptr, 0);
        check("rst_addr",  R_addr,      0);
        check("rst_uf",    R_underflow, 0);
        R_RST = 1'b0;

        // Single entry in, single entry out.
        cycle(1'b0, 1'b1);
        check("one_empty", R_EMPTY, 0);
        check("one_level", R_level, 1);
        cycle(1'b1, 1'b0);
        check("one_rd_empty", R_EMPTY,     1);
        check("one_rd_addr",  R_addr,      1);
        check("one_rd_gray",  Rd_gray_ptr, 5'b00001);

        // Asynchronous reset in the middle of traffic, checked between edges.
        repeat (3) cycle(1'b0, 1'b1);
        check("pre_rst_level", R_level, 3);
        #2 R_RST = 1'b1;
        R_INC        = 1'b0;
        wcnt         = 0;
        Wr_gray_sync = '0;
        #1;
        check("async_empty", R_EMPTY,     1);
        check("async_level", R_level,     0);
        check("async_gray",  Rd_gray_ptr, 0);
        check("async_addr",  R_addr,      0);
        @(negedge R_CLK);
        R_RST = 1'b0;

        // Fill to full, then drain back-to-back.
        repeat (DEPTH) cycle(1'b0, 1'b1);
        check("fill_wgray", Wr_gray_sync, 5'b11000);
        check("fill_level", R_level,      DEPTH);
        check("fill_empty", R_EMPTY,      0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_addr", R_addr, i);
            cycle(1'b1, 1'b0);
        end
        check("drain_empty", R_EMPTY, 1);
        check("drain_level", R_level, 0);

        // Underflow: pointer holds while the pulse repeats.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            check("uf_pulse", R_underflow, 1);
            check("uf_addr",  R_addr,      0);
            check("uf_gray",  Rd_gray_ptr, 5'b11000);
        end
        cycle(1'b0, 1'b0);
        check("uf_clear", R_underflow, 0);

        // Wrap the pointer with paired writes and reads.
        repeat (40) cycle(1'b1, 1'b1);

        // Simultaneous read and write at level 5.
        cycle(1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1);
        check("sim_pre_level", R_level, 5);
        cycle(1'b1, 1'b1);
        check("sim_level", R_level, 5);
        check("sim_empty", R_EMPTY, 0);

        // Randomized traffic.
        repeat (800) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Exhaustive decode with the read pointer at zero.
        do_reset();
        chk_bound = 1'b0;
        for (int g = 0; g < MOD; g++) begin
            Wr_gray_sync = AW'(g);
            @(negedge R_CLK);
            check("decode", R_level, from_gray(AW'(g)));
        end
        Wr_gray_sync = 5'b11000;
        @(negedge R_CLK);
        check("decode_11000", R_level, 16);
        Wr_gray_sync = 5'b10000;
        @(negedge R_CLK);
        check("decode_10000", R_level, 31);
        Wr_gray_sync = 5'b00011;
        @(negedge R_CLK);
        check("decode_00011", R_level, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
